// File: rtl/hsi_coder_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hsi_coder_fifo
// Brief    : HSI serial frame coder with input FIFO; start/data/parity/stop
//            framing paced by the clk_en bit-rate strobe.
// Revision : 1.0
// ============================================================================
module hsi_coder_fifo #(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 2,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int LSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [DATA_W-1:0] d,
    input  logic              wr_en,
    output logic              full,
    output logic              busy,
    output logic              q,
    output logic              frame_done,
    output logic              overflow
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_BW = $clog2(DATA_W);
    localparam logic [c_AW:0]   c_FULL      = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [c_BW-1:0] c_LAST_BIT  = c_BW'(DATA_W - 1);
    localparam logic            c_LAST_STOP = (STOP_BITS == 2);
    localparam logic            c_ODD       = (PARITY_MODE == 2);

    generate
        if (PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
            DATA_W < 5 || DATA_W > 16 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
            $error("hsi_coder_fifo: illegal parameter value");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

    state_t            r_state, w_state_next;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]     r_count, w_count_next;
    logic              w_push, w_pop;
    logic [DATA_W-1:0] w_head;
    logic [DATA_W-1:0] r_shift, w_shift_next;
    logic [c_BW-1:0]   r_bit_cnt, w_bit_cnt_next;
    logic              r_stop_cnt, w_stop_cnt_next;
    logic              r_par, w_par_next;
    logic              w_q_next, w_done;

    // full is the registered flag, so a write while full is dropped even if
    // the serialiser pops in the same cycle.
    assign w_push = wr_en & ~full;
    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_cnt_next  = r_bit_cnt;
        w_stop_cnt_next = r_stop_cnt;
        w_par_next      = r_par;
        w_q_next        = q;
        w_done          = 1'b0;
        w_pop           = 1'b0;
        if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    w_q_next = 1'b1;
                    if (r_count != '0) begin
                        w_pop          = 1'b1;
                        w_shift_next   = w_head;
                        w_par_next     = (^w_head) ^ c_ODD;
                        w_q_next       = 1'b0;
                        w_bit_cnt_next = '0;
                        w_state_next   = S_DATA;
                    end
                end
                S_DATA: begin
                    if (LSB_FIRST != 0) begin
                        w_q_next     = r_shift[0];
                        w_shift_next = r_shift >> 1;
                    end else begin
                        w_q_next     = r_shift[DATA_W-1];
                        w_shift_next = r_shift << 1;
                    end
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_bit_cnt_next  = '0;
                        w_stop_cnt_next = 1'b0;
                        w_state_next    = (PARITY_MODE != 0) ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    w_q_next        = r_par;
                    w_stop_cnt_next = 1'b0;
                    w_state_next    = S_STOP;
                end
                default: begin
                    w_q_next = 1'b1;
                    if (r_stop_cnt == c_LAST_STOP) begin
                        w_done       = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_stop_cnt_next = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par      <= 1'b0;
            q          <= 1'b1;
            full       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_shift    <= w_shift_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_par      <= w_par_next;
            q          <= w_q_next;
            frame_done <= w_done;
            overflow   <= wr_en & full;
            full       <= (w_count_next == c_FULL);
            busy       <= (w_state_next != S_IDLE) || (w_count_next != '0);
            if (w_push) begin
                r_mem[r_wr_ptr] <= d;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
